// File: rtl/timing_nco.sv
// Timing-recovery NCO: phase accumulator stepped once per input sample.
// The per-sample increment is nominal plus a scaled loop-filter correction,
// clamped to a safe range. A carry out of the accumulator marks the on-time
// symbol instant, the MSB rising without carry marks the mid-symbol instant,
// and the residual phase after a wrap is reported as the fractional interval.
module timing_nco #(
  parameter int WERR       = 18,
  parameter int PW         = 24,
  parameter int NOM_INC    = 2097152,
  parameter int CTRL_SHIFT = 4,
  parameter int INC_MIN    = 1835008,
  parameter int INC_MAX    = 2359296,
  parameter int MU_W       = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_val_i,
  input  logic signed [WERR-1:0] ctrl_i,
  input  logic                   ctrl_val_i,
  output logic                   sym_stb_o,
  output logic                   mid_stb_o,
  output logic [MU_W-1:0]        mu_o,
  output logic [PW-1:0]          inc_o,
  output logic                   sat_o
);

  // Wide enough that nominal plus any shifted correction can never overflow.
  localparam int RW = PW + WERR + CTRL_SHIFT + 1;
  localparam logic signed [RW-1:0] C_INC_MIN = RW'(INC_MIN);
  localparam logic signed [RW-1:0] C_INC_MAX = RW'(INC_MAX);

  logic signed [WERR-1:0] r_ctrl;
  logic                   r_ctrl_upd;
  logic [PW-1:0]          r_acc;

  logic signed [RW-1:0]   w_ctrl_ext;
  logic signed [RW-1:0]   w_inc_raw;
  logic                   w_too_low;
  logic                   w_too_high;
  logic [PW-1:0]          w_inc_clamped;
  logic [PW:0]            w_sum;

  // Sign-extend first, then shift, so negative corrections stay negative.
  assign w_ctrl_ext    = RW'(r_ctrl) <<< CTRL_SHIFT;
  assign w_inc_raw     = RW'(NOM_INC) + w_ctrl_ext;
  assign w_too_low     = w_inc_raw < C_INC_MIN;
  assign w_too_high    = w_inc_raw > C_INC_MAX;
  assign w_inc_clamped = w_too_low  ? PW'(INC_MIN) :
                         w_too_high ? PW'(INC_MAX) :
                                      w_inc_raw[PW-1:0];

  // One extra bit holds the carry that marks a symbol wrap.
  assign w_sum = {1'b0, r_acc} + {1'b0, inc_o};

  // Capture the loop-filter correction and note when it was refreshed.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl     <= '0;
      r_ctrl_upd <= 1'b0;
    end else begin
      if (ctrl_val_i) r_ctrl <= ctrl_i;
      r_ctrl_upd <= ctrl_val_i;
    end
  end

  // Register the clamped increment; flag a clamp once per correction update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inc_o <= PW'(NOM_INC);
      sat_o <= 1'b0;
    end else begin
      inc_o <= w_inc_clamped;
      sat_o <= r_ctrl_upd & (w_too_low | w_too_high);
    end
  end

  // Advance the phase per sample and emit strobes one cycle after the sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc     <= '0;
      mu_o      <= '0;
      sym_stb_o <= 1'b0;
      mid_stb_o <= 1'b0;
    end else begin
      sym_stb_o <= in_val_i & w_sum[PW];
      mid_stb_o <= in_val_i & ~w_sum[PW] & ~r_acc[PW-1] & w_sum[PW-1];
      if (in_val_i) begin
        r_acc <= w_sum[PW-1:0];
        if (w_sum[PW]) mu_o <= w_sum[PW-1 -: MU_W];
      end
    end
  end

endmodule

// File: tb/tb_timing_nco.sv
// Self-checking bench for timing_nco. A phase-level reference model predicts
// every output for the cycle after each stimulus cycle; predictions queue up
// and each scenario pops and compares them, alongside fixed expectations.
module tb_timing_nco;

  localparam int PW   = 24;
  localparam int MU_W = 12;
  localparam int WERR = 18;
  localparam longint NOM  = 2097152;
  localparam longint IMIN = 1835008;
  localparam longint IMAX = 2359296;
  localparam longint FULL = longint'(1) << PW;
  localparam longint HALF = longint'(1) << (PW - 1);

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b1;
  logic                   in_val_i = 1'b0;
  logic                   ctrl_val_i = 1'b0;
  logic signed [WERR-1:0] ctrl_i = '0;
  logic                   sym_stb_o;
  logic                   mid_stb_o;
  logic [MU_W-1:0]        mu_o;
  logic [PW-1:0]          inc_o;
  logic                   sat_o;

  typedef struct packed {
    logic            sym;
    logic            mid;
    logic [MU_W-1:0] mu;
    logic [PW-1:0]   inc;
    logic            sat;
  } out_t;

  out_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  longint m_acc  = 0;
  longint m_inc  = NOM;
  longint m_ctrl = 0;
  longint m_mu   = 0;
  bit     m_upd  = 1'b0;

  always #5 clk = ~clk;

  timing_nco dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_val_i   (in_val_i),
    .ctrl_i     (ctrl_i),
    .ctrl_val_i (ctrl_val_i),
    .sym_stb_o  (sym_stb_o),
    .mid_stb_o  (mid_stb_o),
    .mu_o       (mu_o),
    .inc_o      (inc_o),
    .sat_o      (sat_o)
  );

  function automatic out_t observed();
    return {sym_stb_o, mid_stb_o, mu_o, inc_o, sat_o};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("sym=%b mid=%b mu=%0d inc=%0d sat=%b", o.sym, o.mid, o.mu, o.inc, o.sat);
  endfunction

  // Drive one cycle, update the model at the edge, queue the prediction,
  // and return at the following falling edge where outputs are stable.
  task automatic step(input bit rst, input bit v, input bit cv, input int c);
    out_t   e;
    longint sum;
    longint raw;
    reset_n    = !rst;
    in_val_i   = v;
    ctrl_val_i = cv;
    ctrl_i     = c[WERR-1:0];
    @(posedge clk);
    e = '0;
    if (rst) begin
      m_acc  = 0;
      m_ctrl = 0;
      m_inc  = NOM;
      m_mu   = 0;
      m_upd  = 1'b0;
    end else begin
      sum   = m_acc + m_inc;
      e.sym = v && (sum >= FULL);
      e.mid = v && (sum < FULL) && (m_acc < HALF) && (sum >= HALF);
      if (v) begin
        if (sum >= FULL) m_mu = (sum - FULL) >> (PW - MU_W);
        m_acc = sum % FULL;
      end
      raw   = NOM + m_ctrl * 16;
      e.sat = m_upd && (raw < IMIN || raw > IMAX);
      m_inc = (raw < IMIN) ? IMIN : (raw > IMAX) ? IMAX : raw;
      if (cv) m_ctrl = longint'(c);
      m_upd = cv;
    end
    e.inc = PW'(m_inc);
    e.mu  = MU_W'(m_mu);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_t e, o;
    // Inputs are active during reset and must be ignored.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 5000);
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL reset[%0d] got %s want %s", i, fmt(o), fmt(e));
      end
    end
    total++;
    if (inc_o !== 24'd2097152 || sym_stb_o !== 1'b0 || mu_o !== 12'd0) begin
      bad++; $display("FAIL reset_const got %s want inc=2097152 all others 0", fmt(observed()));
    end
  endtask

  task automatic test_nominal();
    out_t e, o;
    for (int n = 1; n <= 24; n++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL nominal_sb v%0d got %s want %s", n, fmt(o), fmt(e));
      end
      total++;
      if (o.sym !== (n % 8 == 0) || o.mid !== (n % 8 == 4) || o.mu !== 12'd0 ||
          o.inc !== 24'd2097152 || o.sat !== 1'b0) begin
        bad++; $display("FAIL nominal_pattern v%0d got %s", n, fmt(o));
      end
    end
  endtask

  task automatic test_positive();
    out_t e, o;
    int   first_sym;
    step(1'b1, 1'b0, 1'b0, 0);
    void'(sb.pop_front());
    step(1'b0, 1'b0, 1'b1, 1024);
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e || o.inc !== 24'd2097152) begin
      bad++; $display("FAIL pos_lat1 got %s want %s", fmt(o), fmt(e));
    end
    step(1'b0, 1'b0, 1'b0, 0);
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e || o.inc !== 24'd2113536) begin
      bad++; $display("FAIL pos_lat2 got %s want %s", fmt(o), fmt(e));
    end
    first_sym = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL pos_sb v%0d got %s want %s", n, fmt(o), fmt(e));
      end
      if (o.sym && first_sym == 0) begin
        first_sym = n;
        total++;
        // 8 * 2113536 - 2^24 = 131072 -> top 12 bits = 32
        if (n != 8 || o.mu !== 12'd32) begin
          bad++; $display("FAIL pos_first_wrap got valid=%0d mu=%0d want valid=8 mu=32", n, o.mu);
        end
      end
    end
    total++;
    if (first_sym == 0) begin
      bad++; $display("FAIL pos_no_wrap got none want sym_stb_o within 20 valids");
    end
  endtask

  task automatic test_clamp();
    out_t e, o;
    int   vals[2];
    logic [PW-1:0] lim[2];
    vals[0] = 131071;  lim[0] = 24'd2359296;
    vals[1] = -131072; lim[1] = 24'd1835008;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b1, vals[k]);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 1'b0, 1'b0, 0);
        e = sb.pop_front(); o = observed(); total++;
        if (o !== e) begin
          bad++; $display("FAIL clamp_sb k%0d c%0d got %s want %s", k, i, fmt(o), fmt(e));
        end
        total++;
        if (o.inc !== lim[k] || o.sat !== (i == 0)) begin
          bad++; $display("FAIL clamp_fixed k%0d c%0d got inc=%0d sat=%b want inc=%0d sat=%b",
                          k, i, o.inc, o.sat, lim[k], (i == 0));
        end
      end
    end
  endtask

  task automatic test_gapped();
    out_t e, o;
    int   nv;
    step(1'b1, 1'b0, 1'b0, 0);
    void'(sb.pop_front());
    nv = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      bit v;
      v = (cyc % 3 == 0);
      if (v) nv++;
      step(1'b0, v, 1'b0, 0);
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL gap_sb cyc%0d got %s want %s", cyc, fmt(o), fmt(e));
      end
      total++;
      if (o.sym !== (v && nv % 8 == 0) || o.mid !== (v && nv % 8 == 4)) begin
        bad++; $display("FAIL gap_pattern cyc%0d valid#%0d got sym=%b mid=%b", cyc, nv, o.sym, o.mid);
      end
    end
  endtask

  task automatic test_collision_reset();
    out_t e, o;
    int   nv;
    step(1'b1, 1'b0, 1'b0, 0);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 1'b0, 0);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 1'b0, 0);
    void'(sb.pop_front());
    // Coincident correction: this sample and the next still use the old step.
    step(1'b0, 1'b1, 1'b1, 1024);
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e || o.inc !== 24'd2097152) begin
      bad++; $display("FAIL coll_old_inc got %s want %s", fmt(o), fmt(e));
    end
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL coll_sb n%0d got %s want %s", n, fmt(o), fmt(e));
      end
    end
    // Mid-symbol reset with active inputs.
    step(1'b1, 1'b1, 1'b1, 5000);
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e || o !== out_t'({1'b0, 1'b0, 12'd0, 24'd2097152, 1'b0})) begin
      bad++; $display("FAIL coll_reset got %s want %s", fmt(o), fmt(e));
    end
    nv = 0;
    for (int n = 1; n <= 9; n++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      nv++;
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin
        bad++; $display("FAIL post_reset_sb v%0d got %s want %s", n, fmt(o), fmt(e));
      end
      total++;
      if (o.sym !== (nv == 8) || (o.sym && o.mu !== 12'd0)) begin
        bad++; $display("FAIL post_reset_sym v%0d got sym=%b mu=%0d want sym=%b mu=0",
                        nv, o.sym, o.mu, (nv == 8));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_positive();
    test_clamp();
    test_gapped();
    test_collision_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
